dm_responder: RTL and testbench
===============================

# dm_responder

Byte-organised data-memory responder that services the active-low `nRD` / `nWR` strobes issued by the control unit toward data memory. It moves one byte per clock, big-endian, and raises a one-cycle `Ready` when a full 32-bit word has been read or written. It sits between the datapath's memory port and the data RAM, and is the first step toward a stall-capable, multicycle memory interface. The current single-cycle memory cannot stall, which is why this block exists.

## Interface

Parameters:
- `DEPTH`, default 128: RAM size in bytes. Must be a power of two and at least 4.

Ports (one synchronous clock domain; reset is synchronous and active-high):
- `CLK`  in  1: single clock. All state updates on the rising edge.
- `Reset`  in  1: synchronous, active-high reset.
- `nRD`  in  1: active-low read strobe. Level-sensitive.
- `nWR`  in  1: active-low write strobe. Level-sensitive.
- `Addr`  in  32: byte address of the word's most-significant byte.
- `DataIn`  in  32: write data.
- `DataOut`  out  32: read data. Registered.
- `Ready`  out  1: one-cycle completion pulse.
- `Busy`  out  1: high while an access is in flight (states BEAT and DONE).
- `Conflict`  out  1: one-cycle pulse when `nRD` and `nWR` are sampled low together in IDLE.

## Operation

- Storage: `DEPTH` × 8-bit array.
  - Contents are not affected by `Reset`.
  - Byte index is `(A + i) mod DEPTH`, where `A` is the latched `Addr` reduced mod `DEPTH` (low log2(`DEPTH`) bits) and `i` is the beat index.
  - Unaligned addresses are legal and wrap around the top of the array.
- Byte order is big-endian: beat `i` carries bits `[31-8i : 24-8i]`.
- FSM states:
  - IDLE:
    - `nWR`=0 → latch `Addr` and `DataIn`, op=WRITE, beat=0, go to BEAT.
    - Else `nRD`=0 → latch `Addr`, op=READ, beat=0, go to BEAT.
    - Both low → WRITE wins, and `Conflict` pulses during the sampling cycle (combinational from IDLE and both strobes low).
    - Neither low → stay in IDLE.
  - BEAT:
    - WRITE: byte `i` of the latched data is written to `mem[(A+i) mod DEPTH]`.
    - READ: `mem[(A+i) mod DEPTH]` is captured into byte `i` of an internal shadow register.
    - beat increments by 1. After beat 3, go to DONE.
    - Strobes are ignored while in BEAT.
  - DONE:
    - `Ready`=1.
    - READ: `DataOut` ← shadow register at this cycle's edge.
    - Always go to IDLE.
- `DataOut` holds its value until the next completed read. It is never disturbed by writes or by aborted reads.
- Strobes are not required to drop after `Ready`. If a strobe is still low in IDLE, a new access begins; the requester deasserts it itself.
- Latched `Addr`/`DataIn` are used for the whole access. Input changes after sampling have no effect.

## Timing

- Reset values: state=IDLE, beat=0, `Ready`=0, `Busy`=0, `Conflict`=0, `DataOut`=32'h0000_0000, shadow=0.
- Latency, with the request sampled at edge E0:
  - BEAT occupies the cycles after E0, E1, E2 and E3.
  - DONE is the cycle after E4. `Ready` is high for exactly that cycle.
  - Read data appears on `DataOut` after E5.
  - The earliest next sampling is at E6, so back-to-back throughput is one word per 6 cycles.
- Write visibility: byte `i` is in the RAM after edge E(i+1). A read sampled at E6 or later returns the full new word.
- Reset mid-access:
  - Return to IDLE at the reset edge; `Ready`, `Busy`, `Conflict`=0.
  - Bytes already written stay written; remaining bytes are not written.
  - An aborted read leaves `DataOut`=0 (reset value).
- Reset together with a strobe: reset wins. No access starts at that edge.
- `Ready`, `Busy` and `Conflict` are never X after the first reset edge.

## Test plan

- Aligned write then read, `DEPTH`=128:
  - `nWR`=0, `Addr`=0x10, `DataIn`=0x1234_5678 → `Ready` 5 cycles after sampling.
  - mem[0x10..0x13]=12,34,56,78.
  - A subsequent `nRD` at 0x10 → `DataOut`=0x1234_5678 one cycle after its `Ready`.
- Wrap-around:
  - Write 0xAABB_CCDD at `Addr`=0x7E → mem[0x7E]=AA, mem[0x7F]=BB, mem[0x00]=CC, mem[0x01]=DD.
  - Reading back at `Addr`=0x7E returns 0xAABB_CCDD.
  - `Addr`=0xFE aliases to the same word.
- Conflict:
  - `nRD`=`nWR`=0 in IDLE → `Conflict`=1 for one cycle and the write executes.
  - `DataOut` is unchanged.
- Held strobe:
  - Keep `nRD`=0 for 14 cycles → exactly two `Ready` pulses, 6 cycles apart.
  - `Busy` is low only in the IDLE sampling cycles.
- Input change mid-access:
  - Change `Addr`/`DataIn` during BEAT → the stored word matches the values sampled at E0.
- Reset mid-write:
  - Assert `Reset` after E2 of a write of 0xDEAD_BEEF to 0x20 → mem[0x20]=DE and mem[0x21]=AD.
  - mem[0x22..0x23] keep their prior contents.
  - All outputs are at their reset values.

Source files
------------

// File: rtl/dm_responder_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dm_responder_if: strobe/address/data bundle between requester and     |
// | the byte-serial data-memory responder.  Rev 1.0                       |
// +----------------------------------------------------------------------+
interface dm_responder_if;
  logic        nRD;
  logic        nWR;
  logic [31:0] Addr;
  logic [31:0] DataIn;
  logic [31:0] DataOut;
  logic        Ready;
  logic        Busy;
  logic        Conflict;

  modport master (
    output nRD, nWR, Addr, DataIn,
    input  DataOut, Ready, Busy, Conflict
  );

  modport slave (
    input  nRD, nWR, Addr, DataIn,
    output DataOut, Ready, Busy, Conflict
  );
endinterface
`default_nettype wire

// File: rtl/dm_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dm_responder: moves one byte per clock, big-endian, between the      |
// | memory port and a DEPTH-byte RAM; pulses Ready per 32-bit word.      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module dm_responder #(
  parameter int DEPTH = 128
) (
  input  wire logic CLK,
  input  wire logic Reset,
  dm_responder_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BEAT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  logic [1:0]      r_beat;
  logic            r_op_wr;
  logic [AW-1:0]   r_addr;
  logic [31:0]     r_wdata;
  logic [31:0]     r_shadow;
  logic [31:0]     r_dataout;
  logic            r_ready;
  logic            r_busy;
  logic [7:0]      r_mem [DEPTH];

  logic [AW-1:0]   w_idx;

  // Address arithmetic is AW bits wide, so the byte index wraps mod DEPTH.
  assign w_idx = r_addr + AW'(r_beat);

  assign bus.Conflict = !Reset && (r_state == S_IDLE) && !bus.nWR && !bus.nRD;
  assign bus.DataOut  = r_dataout;
  assign bus.Ready    = r_ready;
  assign bus.Busy     = r_busy;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_state   <= S_IDLE;
      r_beat    <= 2'd0;
      r_op_wr   <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= 32'h0;
      r_shadow  <= 32'h0;
      r_dataout <= 32'h0;
      r_ready   <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_ready <= 1'b0;
          if (!bus.nWR) begin
            r_op_wr <= 1'b1;
            r_addr  <= bus.Addr[AW-1:0];
            r_wdata <= bus.DataIn;
            r_beat  <= 2'd0;
            r_busy  <= 1'b1;
            r_state <= S_BEAT;
          end else if (!bus.nRD) begin
            r_op_wr <= 1'b0;
            r_addr  <= bus.Addr[AW-1:0];
            r_beat  <= 2'd0;
            r_busy  <= 1'b1;
            r_state <= S_BEAT;
          end
        end
        S_BEAT: begin
          // Both data paths shift MSB-first, which yields big-endian order.
          if (r_op_wr) begin
            r_wdata <= {r_wdata[23:0], 8'h00};
          end else begin
            r_shadow <= {r_shadow[23:0], r_mem[w_idx]};
          end
          r_beat <= r_beat + 2'd1;
          if (r_beat == 2'd3) begin
            r_state <= S_DONE;
            r_ready <= 1'b1;
          end
        end
        S_DONE: begin
          r_ready <= 1'b0;
          r_busy  <= 1'b0;
          if (!r_op_wr) begin
            r_dataout <= r_shadow;
          end
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // RAM contents survive reset; a reset edge only suppresses the pending byte.
  always_ff @(posedge CLK) begin
    if (!Reset && (r_state == S_BEAT) && r_op_wr) begin
      r_mem[w_idx] <= r_wdata[31:24];
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_dm_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_dm_responder: directed vector table plus hand-written multi-cycle  |
// | sequences for dm_responder.  Rev 1.0                                  |
// +----------------------------------------------------------------------+
module tb_dm_responder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dm_responder_if bus ();

  dm_responder #(.DEPTH(128)) dut (
    .CLK   (clk),
    .Reset (rst),
    .bus   (bus)
  );

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp_out;
  } vec_t;

  vec_t vec [9];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Issues one access, returns the number of edges after sampling until Ready
  // is seen (-1 on timeout), and returns at the negedge after the DONE edge.
  task automatic access(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                        output int lat);
    @(negedge clk);
    bus.nWR    = !wr;
    bus.nRD    = wr;
    bus.Addr   = addr;
    bus.DataIn = data;
    @(posedge clk);
    @(negedge clk);
    bus.nWR = 1'b1;
    bus.nRD = 1'b1;
    lat = -1;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.Ready === 1'b1) begin
        lat = k;
        break;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_idle(input string name);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus.Busy === 1'b0) break;
    end
    check(name, {31'h0, bus.Busy}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat;
    int rdy_cnt, first_rdy, second_rdy, busy_bad;

    vec[0] = '{1'b1, 32'h0000_0010, 32'h1234_5678, 32'h0000_0000};
    vec[1] = '{1'b0, 32'h0000_0010, 32'h0,         32'h1234_5678};
    vec[2] = '{1'b1, 32'h0000_007E, 32'hAABB_CCDD, 32'h1234_5678};
    vec[3] = '{1'b0, 32'h0000_007E, 32'h0,         32'hAABB_CCDD};
    vec[4] = '{1'b0, 32'h0000_00FE, 32'h0,         32'hAABB_CCDD};
    vec[5] = '{1'b1, 32'h0000_0200, 32'h0102_0304, 32'hAABB_CCDD};
    vec[6] = '{1'b0, 32'h0000_007E, 32'h0,         32'hAABB_0102};
    vec[7] = '{1'b0, 32'hFFFF_FF90, 32'h0,         32'h1234_5678};
    vec[8] = '{1'b0, 32'h0000_0000, 32'h0,         32'h0102_0304};

    bus.nRD = 1'b1;
    bus.nWR = 1'b1;
    bus.Addr = 32'h0;
    bus.DataIn = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset Ready",    {31'h0, bus.Ready},    32'h0);
    check("reset Busy",     {31'h0, bus.Busy},     32'h0);
    check("reset Conflict", {31'h0, bus.Conflict}, 32'h0);
    check("reset DataOut",  bus.DataOut,           32'h0);

    // A strobe coinciding with reset must not start an access.
    bus.nWR = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("reset+strobe Busy", {31'h0, bus.Busy}, 32'h0);
    rst = 1'b0;
    bus.nWR = 1'b1;

    foreach (vec[i]) begin
      access(vec[i].wr, vec[i].addr, vec[i].data, lat);
      check($sformatf("vec%0d ready latency", i), 32'(lat), 32'd4);
      check($sformatf("vec%0d DataOut", i), bus.DataOut, vec[i].exp_out);
      check($sformatf("vec%0d Busy after", i), {31'h0, bus.Busy}, 32'h0);
    end

    // Simultaneous strobes: write wins, Conflict pulses only in the sampling cycle.
    @(negedge clk);
    bus.nWR = 1'b0;
    bus.nRD = 1'b0;
    bus.Addr = 32'h40;
    bus.DataIn = 32'hCAFE_F00D;
    #1;
    check("conflict pulse", {31'h0, bus.Conflict}, 32'h1);
    @(posedge clk);
    @(negedge clk);
    check("conflict drop", {31'h0, bus.Conflict}, 32'h0);
    bus.nWR = 1'b1;
    bus.nRD = 1'b1;
    wait_idle("conflict idle");
    check("conflict DataOut kept", bus.DataOut, 32'h0102_0304);
    access(1'b0, 32'h40, 32'h0, lat);
    check("conflict write readback", bus.DataOut, 32'hCAFE_F00D);

    // Held read strobe for 14 edges.
    @(negedge clk);
    bus.nRD = 1'b0;
    bus.Addr = 32'h10;
    rdy_cnt = 0;
    first_rdy = -1;
    second_rdy = -1;
    busy_bad = 0;
    for (int j = 0; j < 14; j++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.Ready === 1'b1) begin
        rdy_cnt++;
        if (first_rdy < 0) first_rdy = j;
        else if (second_rdy < 0) second_rdy = j;
      end
      if (bus.Busy !== logic'((j % 6) != 5)) busy_bad++;
    end
    bus.nRD = 1'b1;
    check("held ready count", 32'(rdy_cnt), 32'd2);
    check("held first ready", 32'(first_rdy), 32'd4);
    check("held ready spacing", 32'(second_rdy - first_rdy), 32'd6);
    check("held busy pattern errors", 32'(busy_bad), 32'd0);
    wait_idle("held idle");
    check("held DataOut", bus.DataOut, 32'h1234_5678);

    // Inputs changing during BEAT must not affect the access.
    @(negedge clk);
    bus.nWR = 1'b0;
    bus.Addr = 32'h50;
    bus.DataIn = 32'h0BAD_CAFE;
    @(posedge clk);
    @(negedge clk);
    bus.nWR = 1'b1;
    bus.Addr = 32'h60;
    bus.DataIn = 32'hFFFF_FFFF;
    wait_idle("midchange idle");
    access(1'b0, 32'h50, 32'h0, lat);
    check("midchange readback", bus.DataOut, 32'h0BAD_CAFE);

    // Reset after two bytes of a write have landed.
    access(1'b1, 32'h20, 32'h1122_3344, lat);
    @(negedge clk);
    bus.nWR = 1'b0;
    bus.Addr = 32'h20;
    bus.DataIn = 32'hDEAD_BEEF;
    @(posedge clk);
    @(negedge clk);
    bus.nWR = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midreset Ready",   {31'h0, bus.Ready}, 32'h0);
    check("midreset Busy",    {31'h0, bus.Busy},  32'h0);
    check("midreset DataOut", bus.DataOut,        32'h0);
    rst = 1'b0;
    access(1'b0, 32'h20, 32'h0, lat);
    check("midreset partial word", bus.DataOut, 32'hDEAD_3344);

    // Reset during a read: DataOut stays at its reset value.
    @(negedge clk);
    bus.nRD = 1'b0;
    bus.Addr = 32'h10;
    @(posedge clk);
    @(negedge clk);
    bus.nRD = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("aborted read DataOut", bus.DataOut, 32'h0);
    check("aborted read Busy", {31'h0, bus.Busy}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
